// File: rtl/alu_if.sv
// alu_if: operand/op inputs and result/zero outputs of the ALU
interface alu_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       op;
    logic [WIDTH-1:0] result;
    logic             zero;
    modport master (output data1, data2, op, input result, zero);
    modport slave (input data1, data2, op, output result, zero);
endinterface

// File: rtl/alu.sv
// alu: single-cycle MIPS ALU with a registered reset-hold that forces result=0, zero=1
module alu #(parameter int WIDTH = 32) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    logic             rst_q;
    logic [WIDTH-1:0] r;
    always_ff @(posedge clk) rst_q <= reset;
    // full-width shift amount: data2 >= WIDTH shifts everything out
    always_comb begin
        r = rst_q              ? '0 :
            bus.op == 3'b000   ? bus.data1 & bus.data2 :
            bus.op == 3'b001   ? bus.data1 | bus.data2 :
            bus.op == 3'b010   ? bus.data1 + bus.data2 :
            bus.op == 3'b110   ? bus.data1 - bus.data2 :
            bus.op == 3'b111   ? bus.data1 << bus.data2 :
                                 '0;
    end
    assign bus.result = r;
    assign bus.zero   = ~|r;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random self-checking bench for alu
module tb_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    alu_if bus ();
    alu u_alu (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [31:0] m;
        m = 32'h0;
        if (op == 3'b000) m = a & b;
        else if (op == 3'b001) m = a | b;
        else if (op == 3'b010) m = a + b;
        else if (op == 3'b110) m = a + ~b + 32'h1;
        else if (op == 3'b111) m = (b > 32'd31) ? 32'h0 : (a << b[4:0]);
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] er, input logic ez);
        checks++;
        assert (bus.result === er) else begin
            errors++;
            $error("FAIL %s result got %h want %h", tag, bus.result, er);
        end
        checks++;
        assert (bus.zero === ez) else begin
            errors++;
            $error("FAIL %s zero got %b want %b", tag, bus.zero, ez);
        end
    endtask

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.data1 = a;
        bus.data2 = b;
        bus.op    = op;
        #1;
    endtask

    initial begin
        logic [31:0] a, b, e;
        logic [2:0]  o;
        bus.data1 = 32'hFFFFFFFF;
        bus.data2 = 32'hFFFFFFFF;
        bus.op    = 3'b010;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_hold", 32'h0, 1'b1);
        @(posedge clk); #1;
        check("reset_hold2", 32'h0, 1'b1);
        reset = 1'b0;
        #1;
        check("reset_before_edge", 32'h0, 1'b1);
        @(posedge clk); #1;
        check("reset_release", 32'hFFFFFFFE, 1'b0);

        apply(32'hF0F0A5A5, 32'h0FF0FF00, 3'b000); check("and", 32'h00F0A500, 1'b0);
        apply(32'hF0F0A5A5, 32'h0FF0FF00, 3'b001); check("or", 32'hFFF0FFA5, 1'b0);
        apply(32'hAAAAAAAA, 32'h55555555, 3'b000); check("and_zero", 32'h0, 1'b1);
        apply(32'hAAAAAAAA, 32'h55555555, 3'b001); check("or_ones", 32'hFFFFFFFF, 1'b0);
        apply(32'hFFFFFFFF, 32'h00000001, 3'b010); check("add_wrap", 32'h0, 1'b1);
        apply(32'h00001234, 32'h00000FFF, 3'b010); check("add", 32'h00002233, 1'b0);
        apply(32'h00000000, 32'h00000001, 3'b110); check("sub_wrap", 32'hFFFFFFFF, 1'b0);
        apply(32'h12345678, 32'h12345678, 3'b110); check("sub_eq", 32'h0, 1'b1);
        apply(32'h00000010, 32'h00000003, 3'b110); check("sub", 32'h0000000D, 1'b0);
        apply(32'h00000001, 32'd31, 3'b111); check("sll31", 32'h80000000, 1'b0);
        apply(32'h0000000F, 32'd4, 3'b111); check("sll4", 32'h000000F0, 1'b0);
        apply(32'h0000000F, 32'd32, 3'b111); check("sll32", 32'h0, 1'b1);
        apply(32'h00000001, 32'h00000021, 3'b111); check("sll33", 32'h0, 1'b1);
        apply(32'h00000001, 32'h80000000, 3'b111); check("sll_huge", 32'h0, 1'b1);
        apply(32'hDEADBEEF, 32'd0, 3'b111); check("sll0", 32'hDEADBEEF, 1'b0);
        apply(32'h12345678, 32'h12345678, 3'b011); check("op011", 32'h0, 1'b1);
        apply(32'h12345678, 32'h12345678, 3'b100); check("op100", 32'h0, 1'b1);
        apply(32'h12345678, 32'h12345678, 3'b101); check("op101", 32'h0, 1'b1);

        apply(32'h00000005, 32'h00000007, 3'b001);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", 32'h0, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_release", 32'h00000007, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            o = 3'($urandom_range(0, 7));
            b = (o == 3'b111 && $urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 15) == 0) b = a;
            apply(a, b, o);
            e = model(a, b, o);
            check("random", e, e == 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit single-cycle-MIPS ALU; combinational datapath selected by a 3-bit operation code.
- Produces a result word and a zero flag; zero drives branch decisions (e.g. BEQ via SUB).
- One registered element: a synchronous reset-hold flag that forces outputs to a known state while the core is in reset.

Parameters:
- WIDTH, 32, datapath width of data1, data2 and result.

Ports:
- clk  input  1  system clock; the only clock; rising-edge active.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- data1  input  WIDTH  operand A (shift source for SLL).
- data2  input  WIDTH  operand B (shift amount for SLL).
- op  input  3  operation select.
- result  output  WIDTH  operation result.
- zero  output  1  high when result equals 0.

Behaviour:
- Reset-hold flag rst_q: on each rising clk edge, rst_q <= reset. No other state.
- While rst_q = 1: result = 0, zero = 1, regardless of op/data.
- While rst_q = 0: result is purely combinational from data1, data2, op; no clock latency; output settles within the same cycle as input changes.
- Power-up before the first clk edge: rst_q undefined; the system must apply reset for at least one clk edge.
- Reset deasserted mid-operation: outputs return to the combinational function on the first rising edge sampling reset = 0; no residual state.
- Op encoding, all arithmetic modulo 2^WIDTH, operands unsigned bit vectors:
  - 000 AND: data1 & data2.
  - 001 OR: data1 | data2.
  - 010 ADD: data1 + data2, carry-out discarded (wrap-around).
  - 110 SUB: data1 - data2, two's complement, borrow discarded (0 - 1 = 0xFFFFFFFF).
  - 111 SLL: data1 shifted left by data2, zero-filled. The full data2 value is the shift amount; data2 >= WIDTH gives result 0 (no masking to 5 bits).
  - 011, 100, 101 (unused): result = 0, zero = 1.
- zero = 1 if and only if all bits of result are 0; derived from the final (post-reset-gating) result.
- No X propagation from unused op codes; all outputs are driven in every case.

Test Plan:
- Reset: assert reset for 1+ clk edges with data1=0xFFFFFFFF, data2=0xFFFFFFFF, op=010 -> result=0, zero=1. Deassert at an edge -> result=0xFFFFFFFE, zero=0 after that edge.
- Logic: data1=0xF0F0A5A5, data2=0x0FF0FF00, op=000 -> 0x00F0A500, zero=0. op=001 -> 0xFFF0FFA5, zero=0. data1=0xAAAAAAAA, data2=0x55555555, op=000 -> 0, zero=1.
- Add/sub wrap: op=010, 0xFFFFFFFF+0x00000001 -> 0, zero=1. op=110, 0x00000000-0x00000001 -> 0xFFFFFFFF, zero=0. op=110, 0x12345678-0x12345678 -> 0, zero=1.
- Shift: op=111, data1=0x00000001, data2=31 -> 0x80000000. data2=4, data1=0x0000000F -> 0x000000F0. data2=32 -> 0, zero=1. data2=0 -> data1 unchanged.
- Unused ops: op=011/100/101 with data1=data2=0x12345678 -> result=0, zero=1.
- Random: 1000 random data1/data2/op vectors with reset low -> result matches the reference model above, and zero == (result==0), checked combinationally 1 time unit after each input change.
